// File: rtl/retire_trace_buffer_if.sv
// Retire-trace buffer bus: retire lanes and halt in, show-ahead read port and
// status out. "master" is the CPU/consumer side; "slave" is the buffer.
interface retire_trace_buffer_if #(
  parameter int CHANNELS = 1,
  parameter int DEPTH    = 16,
  parameter int PC_W     = 16,
  parameter int ADDR_W   = 16,
  parameter int DATA_W   = 16
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic [CHANNELS-1:0]        ret_valid;
  logic [2*CHANNELS-1:0]      ret_kind;
  logic [PC_W*CHANNELS-1:0]   ret_pc;
  logic [ADDR_W*CHANNELS-1:0] ret_addr;
  logic [DATA_W*CHANNELS-1:0] ret_data;
  logic                       halt;

  logic                       rd_ready;
  logic                       rd_valid;
  logic [1:0]                 rd_kind;
  logic [PC_W-1:0]            rd_pc;
  logic [ADDR_W-1:0]          rd_addr;
  logic [DATA_W-1:0]          rd_data;

  logic [CNT_W-1:0]           count;
  logic                       overflow;
  logic [15:0]                drop_cnt;
  logic                       frozen;

  modport master (
    output ret_valid, ret_kind, ret_pc, ret_addr, ret_data, halt, rd_ready,
    input  rd_valid, rd_kind, rd_pc, rd_addr, rd_data,
    input  count, overflow, drop_cnt, frozen
  );

  modport slave (
    input  ret_valid, ret_kind, ret_pc, ret_addr, ret_data, halt, rd_ready,
    output rd_valid, rd_kind, rd_pc, rd_addr, rd_data,
    output count, overflow, drop_cnt, frozen
  );
endinterface

// File: rtl/retire_trace_buffer.sv
// Commit-trace recorder: compacts up to CHANNELS retire records per cycle into
// a DEPTH-entry ring and drains them in program order through a show-ahead port.
module retire_trace_buffer #(
  parameter int CHANNELS = 1,
  parameter int DEPTH    = 16,
  parameter int PC_W     = 16,
  parameter int ADDR_W   = 16,
  parameter int DATA_W   = 16,
  parameter int WRAP     = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  retire_trace_buffer_if.slave bus
);
  localparam int PTR_W  = $clog2(DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int WIDE_W = CNT_W + 1;
  localparam logic [CNT_W-1:0]  DEPTH_C = CNT_W'(DEPTH);
  localparam logic [WIDE_W-1:0] DEPTH_W = WIDE_W'(DEPTH);

  typedef enum logic [1:0] {
    KIND_REG   = 2'd0,
    KIND_STORE = 2'd1,
    KIND_JUMP  = 2'd2,
    KIND_RSVD  = 2'd3
  } kind_e;

  typedef struct packed {
    kind_e             kind;
    logic [PC_W-1:0]   pc;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } rec_t;

  rec_t              mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              overflow_q, overflow_d;
  logic              frozen_q, frozen_d;
  logic [15:0]       drop_cnt_q, drop_cnt_d;

  rec_t              lane_rec [CHANNELS];
  logic [CNT_W-1:0]  lane_off [CHANNELS];
  logic [CHANNELS-1:0] lane_ok;
  logic [CHANNELS-1:0] lane_wr;

  logic [CNT_W-1:0]  k;
  logic [CNT_W-1:0]  free_slots;
  logic [CNT_W-1:0]  accepted;
  logic [CNT_W-1:0]  lost;
  logic [WIDE_W-1:0] total;
  logic [16:0]       drop_sum;
  logic              rd_valid;
  logic              pop;
  rec_t              head;

  assign rd_valid = (count_q != '0);
  assign pop      = rd_valid & bus.rd_ready;

  // Lane compaction: each live lane gets the slot offset equal to the number of
  // live lanes below it. Reserved kinds and a frozen buffer contribute nothing.
  always_comb begin
    k = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      lane_rec[i] = '{kind: kind_e'(bus.ret_kind[2*i +: 2]),
                      pc:   bus.ret_pc[i*PC_W +: PC_W],
                      addr: bus.ret_addr[i*ADDR_W +: ADDR_W],
                      data: bus.ret_data[i*DATA_W +: DATA_W]};
      lane_ok[i]  = bus.ret_valid[i] && (bus.ret_kind[2*i +: 2] != KIND_RSVD) && !frozen_q;
      lane_off[i] = k;
      // NOTE: blocking '=' is correct here; k is a running sum consumed by the next lane.
      if (lane_ok[i]) k = k + 1'b1;
    end
  end

  // Occupancy update. A pop in the same cycle releases its slot, so a full
  // buffer that is being read still accepts a record without dropping it.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves one unassigned (no latch).
    free_slots = DEPTH_C - count_q + CNT_W'(pop);
    accepted   = k;
    lost       = '0;
    total      = '0;
    count_d    = count_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    if (WRAP != 0) begin
      total    = WIDE_W'(count_q) - WIDE_W'(pop) + WIDE_W'(k);
      count_d  = (total > DEPTH_W) ? DEPTH_C : total[CNT_W-1:0];
      lost     = CNT_W'(total - WIDE_W'(count_d));
      wr_ptr_d = wr_ptr_q + k[PTR_W-1:0];
      // Head is always the oldest surviving record behind the new write pointer.
      rd_ptr_d = wr_ptr_d - count_d[PTR_W-1:0];
    end else begin
      accepted = (k < free_slots) ? k : free_slots;
      lost     = k - accepted;
      count_d  = count_q + accepted - CNT_W'(pop);
      wr_ptr_d = wr_ptr_q + accepted[PTR_W-1:0];
      rd_ptr_d = rd_ptr_q + PTR_W'(pop);
    end
  end

  always_comb begin
    for (int i = 0; i < CHANNELS; i++) begin
      lane_wr[i] = lane_ok[i] && (lane_off[i] < accepted);
    end
  end

  always_comb begin
    drop_sum   = {1'b0, drop_cnt_q} + 17'(lost);
    drop_cnt_d = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
    overflow_d = overflow_q | (lost != '0);
    frozen_d   = frozen_q | bus.halt;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      frozen_q   <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      frozen_q   <= frozen_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  // NOTE: storage is deliberately not reset; count/pointers define validity.
  always_ff @(posedge clk) begin
    for (int i = 0; i < CHANNELS; i++) begin
      if (lane_wr[i]) mem_q[wr_ptr_q + PTR_W'(lane_off[i])] <= lane_rec[i];
    end
  end

  assign head         = mem_q[rd_ptr_q];
  assign bus.rd_valid = rd_valid;
  assign bus.rd_kind  = head.kind;
  assign bus.rd_pc    = head.pc;
  assign bus.rd_addr  = head.addr;
  assign bus.rd_data  = head.data;
  assign bus.count    = count_q;
  assign bus.overflow = overflow_q;
  assign bus.drop_cnt = drop_cnt_q;
  assign bus.frozen   = frozen_q;
endmodule

// File: tb/tb_retire_trace_buffer.sv
// Directed bench: a stop-when-full instance driven from a vector table and an
// overwrite-oldest instance driven by hand-written sequences.
module tb_retire_trace_buffer;
  localparam int CH = 2, DEPTH = 4, PC_W = 16, ADDR_W = 16, DATA_W = 16;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  retire_trace_buffer_if #(.CHANNELS(CH), .DEPTH(DEPTH), .PC_W(PC_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus0 ();
  retire_trace_buffer_if #(.CHANNELS(CH), .DEPTH(DEPTH), .PC_W(PC_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus1 ();

  retire_trace_buffer #(.CHANNELS(CH), .DEPTH(DEPTH), .PC_W(PC_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .WRAP(0))
    dut0 (.clk(clk), .reset(reset), .bus(bus0));
  retire_trace_buffer #(.CHANNELS(CH), .DEPTH(DEPTH), .PC_W(PC_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .WRAP(1))
    dut1 (.clk(clk), .reset(reset), .bus(bus1));

  typedef struct {
    logic [1:0]  v;
    logic [1:0]  k0; logic [15:0] pc0; logic [15:0] a0; logic [15:0] d0;
    logic [1:0]  k1; logic [15:0] pc1; logic [15:0] a1; logic [15:0] d1;
    logic        halt; logic rdy;
    logic        ev; logic [1:0] ek; logic [15:0] epc; logic [15:0] ea; logic [15:0] ed;
    logic [2:0]  ec; logic eov; logic [15:0] edrop; logic efr;
  } vec_t;

  vec_t vecs [16];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_all();
    bus0.ret_valid = '0; bus0.ret_kind = '0; bus0.ret_pc = '0; bus0.ret_addr = '0;
    bus0.ret_data = '0; bus0.halt = 1'b0; bus0.rd_ready = 1'b0;
    bus1.ret_valid = '0; bus1.ret_kind = '0; bus1.ret_pc = '0; bus1.ret_addr = '0;
    bus1.ret_data = '0; bus1.halt = 1'b0; bus1.rd_ready = 1'b0;
  endtask

  task automatic drive0(input vec_t t);
    bus0.ret_valid = t.v;
    bus0.ret_kind  = {t.k1, t.k0};
    bus0.ret_pc    = {t.pc1, t.pc0};
    bus0.ret_addr  = {t.a1, t.a0};
    bus0.ret_data  = {t.d1, t.d0};
    bus0.halt      = t.halt;
    bus0.rd_ready  = t.rdy;
  endtask

  // Simple register-write records: kind 0, addr 0, data equal to pc.
  task automatic drive_simple(input bit which, input logic [1:0] v, input logic [15:0] pc0,
                              input logic [15:0] pc1, input logic rdy);
    if (which == 1'b0) begin
      bus0.ret_valid = v; bus0.ret_kind = '0; bus0.ret_pc = {pc1, pc0};
      bus0.ret_addr = '0; bus0.ret_data = {pc1, pc0}; bus0.rd_ready = rdy;
    end else begin
      bus1.ret_valid = v; bus1.ret_kind = '0; bus1.ret_pc = {pc1, pc0};
      bus1.ret_addr = '0; bus1.ret_data = {pc1, pc0}; bus1.rd_ready = rdy;
    end
  endtask

  task automatic check_status(input string tag, input bit which, input logic [2:0] ec,
                              input logic eov, input logic [15:0] edrop);
    if (which == 1'b0) begin
      check({tag, ".count"},    32'(bus0.count),    32'(ec));
      check({tag, ".overflow"}, 32'(bus0.overflow), 32'(eov));
      check({tag, ".drop_cnt"}, 32'(bus0.drop_cnt), 32'(edrop));
    end else begin
      check({tag, ".count"},    32'(bus1.count),    32'(ec));
      check({tag, ".overflow"}, 32'(bus1.overflow), 32'(eov));
      check({tag, ".drop_cnt"}, 32'(bus1.drop_cnt), 32'(edrop));
    end
  endtask

  task automatic check_zero_state(input string tag);
    check({tag, ".d0.count"},    32'(bus0.count),    32'd0);
    check({tag, ".d0.rd_valid"}, 32'(bus0.rd_valid), 32'd0);
    check({tag, ".d0.overflow"}, 32'(bus0.overflow), 32'd0);
    check({tag, ".d0.drop_cnt"}, 32'(bus0.drop_cnt), 32'd0);
    check({tag, ".d0.frozen"},   32'(bus0.frozen),   32'd0);
    check({tag, ".d1.count"},    32'(bus1.count),    32'd0);
    check({tag, ".d1.rd_valid"}, 32'(bus1.rd_valid), 32'd0);
  endtask

  initial begin
    //          v      k0    pc0     a0      d0       k1    pc1     a1      d1       h     rdy    ev    ek    epc     ea      ed       ec    eov   edrop   efr
    vecs[0]  = '{2'b11, 2'd0, 16'h10, 16'h3,  16'h00AA, 2'd1, 16'h11, 16'h40, 16'h1234, 1'b0, 1'b0, 1'b1, 2'd0, 16'h10, 16'h3,  16'h00AA, 3'd2, 1'b0, 16'd0, 1'b0};
    vecs[1]  = '{2'b00, 2'd0, 16'h0,  16'h0,  16'h0,    2'd0, 16'h0,  16'h0,  16'h0,    1'b0, 1'b1, 1'b1, 2'd1, 16'h11, 16'h40, 16'h1234, 3'd1, 1'b0, 16'd0, 1'b0};
    vecs[2]  = '{2'b00, 2'd0, 16'h0,  16'h0,  16'h0,    2'd0, 16'h0,  16'h0,  16'h0,    1'b0, 1'b1, 1'b0, 2'd0, 16'h0,  16'h0,  16'h0,    3'd0, 1'b0, 16'd0, 1'b0};
    vecs[3]  = '{2'b11, 2'd3, 16'h77, 16'h7,  16'h7777, 2'd2, 16'h50, 16'h0,  16'h0060, 1'b0, 1'b0, 1'b1, 2'd2, 16'h50, 16'h0,  16'h0060, 3'd1, 1'b0, 16'd0, 1'b0};
    vecs[4]  = '{2'b00, 2'd0, 16'h0,  16'h0,  16'h0,    2'd0, 16'h0,  16'h0,  16'h0,    1'b0, 1'b1, 1'b0, 2'd0, 16'h0,  16'h0,  16'h0,    3'd0, 1'b0, 16'd0, 1'b0};
    vecs[5]  = '{2'b11, 2'd0, 16'h40, 16'h1,  16'h0101, 2'd0, 16'h41, 16'h2,  16'h0202, 1'b0, 1'b0, 1'b1, 2'd0, 16'h40, 16'h1,  16'h0101, 3'd2, 1'b0, 16'd0, 1'b0};
    vecs[6]  = '{2'b11, 2'd1, 16'h42, 16'h80, 16'h0303, 2'd3, 16'h99, 16'h9,  16'h9999, 1'b0, 1'b0, 1'b1, 2'd0, 16'h40, 16'h1,  16'h0101, 3'd3, 1'b0, 16'd0, 1'b0};
    vecs[7]  = '{2'b11, 2'd0, 16'h43, 16'h4,  16'h0404, 2'd0, 16'h44, 16'h5,  16'h0505, 1'b0, 1'b0, 1'b1, 2'd0, 16'h40, 16'h1,  16'h0101, 3'd4, 1'b1, 16'd1, 1'b0};
    vecs[8]  = '{2'b01, 2'd2, 16'h20, 16'h0,  16'h0008, 2'd0, 16'h0,  16'h0,  16'h0,    1'b0, 1'b1, 1'b1, 2'd0, 16'h41, 16'h2,  16'h0202, 3'd4, 1'b1, 16'd1, 1'b0};
    vecs[9]  = '{2'b00, 2'd0, 16'h0,  16'h0,  16'h0,    2'd0, 16'h0,  16'h0,  16'h0,    1'b0, 1'b1, 1'b1, 2'd1, 16'h42, 16'h80, 16'h0303, 3'd3, 1'b1, 16'd1, 1'b0};
    vecs[10] = '{2'b00, 2'd0, 16'h0,  16'h0,  16'h0,    2'd0, 16'h0,  16'h0,  16'h0,    1'b0, 1'b1, 1'b1, 2'd0, 16'h43, 16'h4,  16'h0404, 3'd2, 1'b1, 16'd1, 1'b0};
    vecs[11] = '{2'b00, 2'd0, 16'h0,  16'h0,  16'h0,    2'd0, 16'h0,  16'h0,  16'h0,    1'b0, 1'b1, 1'b1, 2'd2, 16'h20, 16'h0,  16'h0008, 3'd1, 1'b1, 16'd1, 1'b0};
    vecs[12] = '{2'b00, 2'd0, 16'h0,  16'h0,  16'h0,    2'd0, 16'h0,  16'h0,  16'h0,    1'b0, 1'b1, 1'b0, 2'd0, 16'h0,  16'h0,  16'h0,    3'd0, 1'b1, 16'd1, 1'b0};
    vecs[13] = '{2'b01, 2'd0, 16'h30, 16'h6,  16'h0606, 2'd0, 16'h0,  16'h0,  16'h0,    1'b1, 1'b0, 1'b1, 2'd0, 16'h30, 16'h6,  16'h0606, 3'd1, 1'b1, 16'd1, 1'b1};
    vecs[14] = '{2'b11, 2'd0, 16'h31, 16'h7,  16'h0707, 2'd0, 16'h32, 16'h8,  16'h0808, 1'b0, 1'b0, 1'b1, 2'd0, 16'h30, 16'h6,  16'h0606, 3'd1, 1'b1, 16'd1, 1'b1};
    vecs[15] = '{2'b00, 2'd0, 16'h0,  16'h0,  16'h0,    2'd0, 16'h0,  16'h0,  16'h0,    1'b0, 1'b1, 1'b0, 2'd0, 16'h0,  16'h0,  16'h0,    3'd0, 1'b1, 16'd1, 1'b1};

    idle_all();
    reset = 1'b1;
    #12;
    check_zero_state("reset");
    @(negedge clk);
    reset = 1'b0;

    // Stop-when-full instance: table of single-cycle vectors.
    for (int i = 0; i < 16; i++) begin
      drive0(vecs[i]);
      tick();
      check($sformatf("v%0d.count", i),    32'(bus0.count),    32'(vecs[i].ec));
      check($sformatf("v%0d.rd_valid", i), 32'(bus0.rd_valid), 32'(vecs[i].ev));
      check($sformatf("v%0d.overflow", i), 32'(bus0.overflow), 32'(vecs[i].eov));
      check($sformatf("v%0d.drop_cnt", i), 32'(bus0.drop_cnt), 32'(vecs[i].edrop));
      check($sformatf("v%0d.frozen", i),   32'(bus0.frozen),   32'(vecs[i].efr));
      if (vecs[i].ev) begin
        check($sformatf("v%0d.rd_kind", i), 32'(bus0.rd_kind), 32'(vecs[i].ek));
        check($sformatf("v%0d.rd_pc", i),   32'(bus0.rd_pc),   32'(vecs[i].epc));
        check($sformatf("v%0d.rd_addr", i), 32'(bus0.rd_addr), 32'(vecs[i].ea));
        check($sformatf("v%0d.rd_data", i), 32'(bus0.rd_data), 32'(vecs[i].ed));
      end
    end
    idle_all();

    // Overwrite-oldest instance: pcs 1..6, one per cycle, no reads.
    for (int i = 1; i <= 6; i++) begin
      drive_simple(1'b1, 2'b01, 16'(i), 16'h0, 1'b0);
      tick();
      check_status($sformatf("w%0d", i), 1'b1, 3'((i > 4) ? 4 : i), (i > 4), 16'((i > 4) ? i - 4 : 0));
      check($sformatf("w%0d.rd_pc", i), 32'(bus1.rd_pc), 32'((i > 4) ? i - 3 : 1));
    end
    for (int i = 3; i <= 6; i++) begin
      drive_simple(1'b1, 2'b00, 16'h0, 16'h0, 1'b1);
      check($sformatf("wdrain%0d.rd_valid", i), 32'(bus1.rd_valid), 32'd1);
      check($sformatf("wdrain%0d.rd_pc", i),    32'(bus1.rd_pc),    32'(i));
      tick();
    end
    check_status("wempty", 1'b1, 3'd0, 1'b1, 16'd2);

    // Two lanes per cycle into the overwrite instance.
    drive_simple(1'b1, 2'b11, 16'h7, 16'h8, 1'b0);
    tick();
    check_status("w2a", 1'b1, 3'd2, 1'b1, 16'd2);
    check("w2a.rd_pc", 32'(bus1.rd_pc), 32'h7);
    drive_simple(1'b1, 2'b11, 16'h9, 16'hA, 1'b0);
    tick();
    check_status("w2b", 1'b1, 3'd4, 1'b1, 16'd2);
    check("w2b.rd_pc", 32'(bus1.rd_pc), 32'h7);
    drive_simple(1'b1, 2'b11, 16'hB, 16'hC, 1'b0);
    tick();
    check_status("w2c", 1'b1, 3'd4, 1'b1, 16'd4);
    check("w2c.rd_pc", 32'(bus1.rd_pc), 32'h9);
    idle_all();

    // Clear the frozen stop-when-full instance, then build count=3, drop_cnt=5.
    reset = 1'b1;
    #3;
    check_zero_state("reset2");
    @(negedge clk);
    reset = 1'b0;
    drive_simple(1'b0, 2'b11, 16'h60, 16'h61, 1'b0); tick();
    drive_simple(1'b0, 2'b11, 16'h62, 16'h63, 1'b0); tick();
    drive_simple(1'b0, 2'b11, 16'h64, 16'h65, 1'b0); tick();
    drive_simple(1'b0, 2'b11, 16'h66, 16'h67, 1'b0); tick();
    drive_simple(1'b0, 2'b01, 16'h68, 16'h0,  1'b0); tick();
    drive_simple(1'b0, 2'b00, 16'h0,  16'h0,  1'b1); tick();
    idle_all();
    check_status("pre_rst", 1'b0, 3'd3, 1'b1, 16'd5);
    check("pre_rst.rd_pc", 32'(bus0.rd_pc), 32'h61);

    // Asynchronous reset between edges: state must clear without a clock edge.
    #2;
    reset = 1'b1;
    #1;
    check_zero_state("async_rst");
    @(negedge clk);
    reset = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
